dispatcher: RTL and testbench

- Fan-out counterpart of the round-robin input arbiter: takes one valid/ready stream and distributes items round-robin across NUM_OUTPUTS downstream workers (e.g. parallel rasterizer/shader lanes).
- Each output lane has its own FIFO, so one stalled worker never blocks the others while any lane has space.
- Sits between the work-generation stage and the replicated render pipelines.

---
 rtl/dispatcher.sv | 149 ++++++++++++++
 tb/tb_dispatcher.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatcher.sv
// Round-robin fan-out: one valid/ready input stream spread over NUM_OUTPUTS
// lanes, each lane buffered by its own first-word-fall-through FIFO.

module dispatcher_lane #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_SLOTS  = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  push_in,
    input  logic [DATA_WIDTH-1:0] push_data_in,
    input  logic                  pop_ready_in,
    output logic                  full_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid_out
);
    localparam int PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CNT_W = $clog2(NUM_SLOTS + 1);

    logic [DATA_WIDTH-1:0] mem_q [NUM_SLOTS];
    logic [DATA_WIDTH-1:0] mem_d [NUM_SLOTS];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_SLOTS - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign data_valid_out = (count_q != '0);
    assign data_out       = mem_q[rd_ptr_q];
    assign full_out       = (count_q == CNT_W'(NUM_SLOTS));

    always_comb begin
        pop      = data_valid_out && pop_ready_in;
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push_in) begin
            mem_d[wr_ptr_q] = push_data_in;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        // Push and pop together leave the occupancy unchanged.
        case ({push_in, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk_in) begin
        mem_q <= mem_d;
    end
endmodule

module dispatcher #(
    parameter int NUM_OUTPUTS = 4,
    parameter int DATA_WIDTH  = 64,
    parameter int NUM_SLOTS   = 4
) (
    input  logic                                   clk_in,
    input  logic                                   rst_in,
    input  logic [DATA_WIDTH-1:0]                  data_in,
    input  logic                                   data_valid_in,
    output logic                                   ready_out,
    input  logic [NUM_OUTPUTS-1:0]                 receiver_ready,
    output logic [NUM_OUTPUTS-1:0][DATA_WIDTH-1:0] data_out,
    output logic [NUM_OUTPUTS-1:0]                 data_valid_out,
    output logic [$clog2(NUM_OUTPUTS)-1:0]         lane_out
);
    localparam int LANE_W = $clog2(NUM_OUTPUTS);

    logic [NUM_OUTPUTS-1:0] lane_full;
    logic [NUM_OUTPUTS-1:0] lane_push;
    logic [LANE_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [LANE_W-1:0]      target;
    logic [LANE_W-1:0]      scan_idx;
    logic                   found;
    logic                   accept;

    // Target depends only on registered occupancy, so ready_out never
    // waits on this cycle's pops or on data_valid_in.
    always_comb begin
        target   = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int k = 0; k < NUM_OUTPUTS; k++) begin
            scan_idx = LANE_W'((int'(rr_ptr_q) + k) % NUM_OUTPUTS);
            if (!found && !lane_full[scan_idx]) begin
                target = scan_idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        ready_out = found && !rst_in;
        accept    = data_valid_in && ready_out;
        lane_out  = target;
        rr_ptr_d  = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (target == LANE_W'(NUM_OUTPUTS - 1)) ? '0 : target + LANE_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_lane
        assign lane_push[i] = accept && (target == LANE_W'(i));

        dispatcher_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .NUM_SLOTS  (NUM_SLOTS)
        ) u_lane (
            .clk_in         (clk_in),
            .rst_in         (rst_in),
            .push_in        (lane_push[i]),
            .push_data_in   (data_in),
            .pop_ready_in   (receiver_ready[i]),
            .full_out       (lane_full[i]),
            .data_out       (data_out[i]),
            .data_valid_out (data_valid_out[i])
        );
    end
endmodule

// File: tb/tb_dispatcher.sv
// Bench for dispatcher: per-lane queue model checked every cycle, plus
// directed scenarios with hand-computed lane choices and data values.

module tb_dispatcher;
    localparam int N = 4;
    localparam int W = 64;
    localparam int S = 2;

    logic                 clk_in = 1'b0;
    logic                 rst_in;
    logic [W-1:0]         data_in;
    logic                 data_valid_in;
    logic                 ready_out;
    logic [N-1:0]         receiver_ready;
    logic [N-1:0][W-1:0]  data_out;
    logic [N-1:0]         data_valid_out;
    logic [1:0]           lane_out;

    int n_chk  = 0;
    int n_fail = 0;

    logic [W-1:0] mq [N][$];
    int           m_rr;

    dispatcher #(.NUM_OUTPUTS(N), .DATA_WIDTH(W), .NUM_SLOTS(S)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .data_in        (data_in),
        .data_valid_in  (data_valid_in),
        .ready_out      (ready_out),
        .receiver_ready (receiver_ready),
        .data_out       (data_out),
        .data_valid_out (data_valid_out),
        .lane_out       (lane_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: first lane with room, scanning from the round-robin pointer.
    function automatic int m_target();
        for (int k = 0; k < N; k++) begin
            int idx = (m_rr + k) % N;
            if (mq[idx].size() < S) return idx;
        end
        return -1;
    endfunction

    function automatic bit m_ready();
        return !rst_in && (m_target() >= 0);
    endfunction

    task automatic model_step();
        int t;
        if (rst_in) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            m_rr = 0;
        end else begin
            t = m_target();
            for (int i = 0; i < N; i++)
                if (mq[i].size() > 0 && receiver_ready[i]) void'(mq[i].pop_front());
            if (data_valid_in && t >= 0) begin
                mq[t].push_back(data_in);
                m_rr = (t + 1) % N;
            end
        end
    endtask

    always @(posedge clk_in) model_step();

    always @(negedge clk_in) begin
        chk("ready_out", W'(ready_out), W'(m_ready()));
        for (int i = 0; i < N; i++) begin
            chk("data_valid_out", W'(data_valid_out[i]), W'(mq[i].size() > 0));
            if (mq[i].size() > 0) chk("data_out", data_out[i], mq[i][0]);
        end
        if (data_valid_in && m_ready()) chk("lane_out", W'(lane_out), W'(m_target()));
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in        = 1'b1;
        data_valid_in = 1'b0;
        step();
        rst_in        = 1'b0;
    endtask

    int exp1 [8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
    int exp2 [12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 3, 0};

    initial begin
        int           n_acc;
        int           cyc;
        logic [W-1:0] d;

        rst_in         = 1'b1;
        data_valid_in  = 1'b0;
        data_in        = '0;
        receiver_ready = '0;
        m_rr           = 0;
        step();
        step();
        chk("reset ready_out", W'(ready_out), W'(0));
        chk("reset valid", W'(data_valid_out), W'(0));
        rst_in = 1'b0;
        #1;
        chk("post-reset ready_out", W'(ready_out), W'(1));

        // Continuous stream, all workers ready
        receiver_ready = 4'b1111;
        for (int j = 0; j < 8; j++) begin
            data_in       = W'(64'h10 + j);
            data_valid_in = 1'b1;
            #1;
            chk("t1 lane", W'(lane_out), W'(exp1[j]));
            chk("t1 ready", W'(ready_out), W'(1));
            step();
        end
        data_valid_in = 1'b0;
        #1;
        chk("t1 last valid", W'(data_valid_out[3]), W'(1));
        chk("t1 last data", data_out[3], 64'h17);

        // Lane 2 stalled
        do_reset();
        receiver_ready = 4'b1011;
        for (int j = 0; j < 12; j++) begin
            data_in       = W'(64'h20 + j);
            data_valid_in = 1'b1;
            #1;
            chk("t2 lane", W'(lane_out), W'(exp2[j]));
            step();
        end
        data_valid_in = 1'b0;
        #1;
        chk("t2 lane2 held", data_out[2], 64'h22);
        chk("t2 lane2 valid", W'(data_valid_out[2]), W'(1));

        // All stalled: exactly N*S accepts
        do_reset();
        receiver_ready = '0;
        n_acc = 0;
        d     = 64'h30;
        for (int j = 0; j < 12; j++) begin
            data_in       = d;
            data_valid_in = 1'b1;
            #1;
            if (ready_out) begin
                n_acc++;
                d++;
            end
            step();
        end
        chk("t3 accepts", W'(n_acc), W'(8));
        chk("t3 ready low", W'(ready_out), W'(0));
        receiver_ready = 4'b0010;
        step();
        receiver_ready = '0;
        #1;
        chk("t3 ready again", W'(ready_out), W'(1));
        chk("t3 lane after pop", W'(lane_out), W'(1));
        step();
        data_valid_in = 1'b0;

        // Push and pop on lane 0 while it holds one item
        do_reset();
        receiver_ready = '0;
        for (int j = 0; j < 4; j++) begin
            data_in       = W'(64'hA0 + j);
            data_valid_in = 1'b1;
            step();
        end
        data_in        = 64'hA4;
        receiver_ready = 4'b0001;
        #1;
        chk("t4 lane", W'(lane_out), W'(0));
        chk("t4 head before", data_out[0], 64'hA0);
        step();
        data_valid_in  = 1'b0;
        receiver_ready = '0;
        #1;
        chk("t4 valid held", W'(data_valid_out[0]), W'(1));
        chk("t4 new head", data_out[0], 64'hA4);

        // Reset with every lane occupied
        rst_in = 1'b1;
        #1;
        chk("t5 ready in reset", W'(ready_out), W'(0));
        step();
        rst_in = 1'b0;
        #1;
        chk("t5 valid cleared", W'(data_valid_out), W'(0));
        chk("t5 ready", W'(ready_out), W'(1));
        data_in        = 64'hB0;
        data_valid_in  = 1'b1;
        receiver_ready = 4'b1111;
        #1;
        chk("t5 lane", W'(lane_out), W'(0));
        step();
        data_valid_in = 1'b0;

        // Random traffic; the per-cycle model acts as the scoreboard
        do_reset();
        n_acc = 0;
        cyc   = 0;
        d     = 64'h1000;
        while (n_acc < 1000 && cyc < 20000) begin
            data_in        = d;
            data_valid_in  = ($urandom_range(0, 3) != 0);
            receiver_ready = 4'($urandom);
            #1;
            if (data_valid_in && ready_out) begin
                n_acc++;
                d++;
            end
            step();
            cyc++;
        end
        chk("t6 accepted", W'(n_acc), W'(1000));
        data_valid_in  = 1'b0;
        receiver_ready = 4'b1111;
        step();
        step();
        step();
        chk("t6 drained", W'(data_valid_out), W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
